// File: rtl/vault_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vault_pkg
// Shared types and constants for the vault combination sequencer.
//   vault_state_t  : sequencer state encoding
//   DEFAULT_CODE   : combination loaded at reset (entry i uses DEFAULT_CODE[i])
//   default_code() : default entry for a step index, wraps past the table end
//   expected_dir() : required dial direction for a step (1 = up, 0 = down)
//   LED_*          : bit positions on the board LED bus
// -----------------------------------------------------------------------------
package vault_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_OPEN,
    ST_RELOCK,
    ST_LOCKOUT,
    ST_PROG
  } vault_state_t;

  localparam int DEFAULT_LEN = 8;
  localparam int DEFAULT_CODE [DEFAULT_LEN] = '{7, 20, 3, 12, 25, 9, 30, 15};

  function automatic int default_code(input int idx);
    return DEFAULT_CODE[idx % DEFAULT_LEN];
  endfunction

  // Steps alternate up / down, starting with up on step 0.
  function automatic logic expected_dir(input int idx);
    return (idx % 2) == 0;
  endfunction

  localparam int LED_LOCKED   = 0;
  localparam int LED_ENTRY    = 1;
  localparam int LED_UNLOCKED = 2;
  localparam int LED_LOCKOUT  = 3;
  localparam int LED_DIR      = 4;
  localparam int LED_CODE_LSB = 5;

endpackage

// File: rtl/vault_sequencer_lockout_timer.sv
// -----------------------------------------------------------------------------
// lockout_timer
// Loadable down-counter used to time the failed-attempt lockout.
//   clock    in  system clock
//   n_reset  in  asynchronous active-low reset (count cleared to 0)
//   load     in  load LOCKOUT_CYCLES-1 (has priority over count_en)
//   count_en in  decrement by one
//   zero     out count is 0
// -----------------------------------------------------------------------------
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic n_reset,
  input  logic load,
  input  logic count_en,
  output logic zero
);

  // Only needs to hold LOCKOUT_CYCLES-1.
  localparam int CNT_W = $clog2(LOCKOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(LOCKOUT_CYCLES - 1);
    end else if (count_en) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/vault_sequencer.sv
// -----------------------------------------------------------------------------
// vault_sequencer
// Checks detent-by-detent dial moves against a NUM_STEPS combination that
// alternates up/down, counts consecutive failures, enforces a timed lockout
// after MAX_FAILS of them, and drives the unlock output and board LEDs.
// Optional feature macro VAULT_PROG_EN: lets an open vault reprogram its
// combination through prog/set; without it the combination is fixed and
// prog/set are ignored.
//
// Ports
//   clock       in   system clock, rising edge
//   n_reset     in   asynchronous active-low reset
//   direction   in   direction of the current move (1 = up, 0 = down)
//   vault_code  in   dial position after the current move
//   code_valid  in   one-cycle strobe per detent move
//   prog        in   level, request to reprogram while open
//   set         in   strobe, store vault_code as next combination entry
//   unlocked    out  vault open (OPEN or PROG)
//   lockout     out  lockout active
//   step        out  entry / programming index (0 in other states)
//   fail_count  out  consecutive failures
//   led         out  [0] LOCKED [1] ENTRY [2] unlocked [3] lockout
//                    [4] direction [9:5] vault_code[4:0]
// -----------------------------------------------------------------------------
module vault_sequencer
  import vault_pkg::*;
#(
  parameter int CODE_W         = 5,
  parameter int NUM_STEPS      = 3,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                           clock,
  input  logic                           n_reset,
  input  logic                           direction,
  input  logic [CODE_W-1:0]              vault_code,
  input  logic                           code_valid,
  input  logic                           prog,
  input  logic                           set,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(NUM_STEPS)-1:0]   step,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [9:0]                     led
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [CODE_W-1:0] CODE_ONES  = '1;

  vault_state_t      state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic [CODE_W-1:0] comb_q [NUM_STEPS];

  logic              timer_load, timer_en, timer_zero;
  logic              prog_req, prog_write, prog_commit;
  logic [CODE_W-1:0] target;
  logic              exp_up, hit, wrong_dir, overshoot;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .n_reset (n_reset),
    .load    (timer_load),
    .count_en(timer_en),
    .zero    (timer_zero)
  );

  assign timer_en = (state_q == ST_LOCKOUT) && !timer_zero;
  assign fail_inc = fail_q + 1'b1;

  // Entry checks against the current step. Overshoot includes the dial
  // wrapping past its end stop in the required direction.
  always_comb begin
    target    = comb_q[step_q];
    exp_up    = expected_dir(int'(step_q));
    hit       = (direction == exp_up) && (vault_code == target);
    wrong_dir = (direction != exp_up);
    overshoot = exp_up ? ((vault_code > target) || (vault_code == '0))
                       : ((vault_code < target) || (vault_code == CODE_ONES));
  end

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_LOCKED;
      step_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_d     = state_q;
    step_d      = step_q;
    fail_d      = fail_q;
    timer_load  = 1'b0;
    prog_write  = 1'b0;
    prog_commit = 1'b0;

    unique case (state_q)
      ST_LOCKED: begin
        if (code_valid && !direction && (vault_code == '0)) begin
          state_d = ST_ENTRY;
          step_d  = '0;
        end
      end

      ST_ENTRY: begin
        if (code_valid) begin
          if (hit) begin
            if (step_q == LAST_STEP) begin
              state_d = ST_OPEN;
              step_d  = '0;
              fail_d  = '0;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else if (wrong_dir || overshoot) begin
            step_d = '0;
            fail_d = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d    = ST_LOCKOUT;
              timer_load = 1'b1;
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end
      end

      // Leave after the cycle in which the timer shows zero, so the state
      // spans exactly LOCKOUT_CYCLES cycles from the load.
      ST_LOCKOUT: begin
        if (timer_zero) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end

      ST_OPEN: begin
        if (prog_req) begin
          state_d = ST_PROG;
          step_d  = '0;
        end else if (code_valid && !direction) begin
          state_d = ST_RELOCK;
        end
      end

      ST_RELOCK: begin
        if (code_valid && !direction && (vault_code == '0)) begin
          state_d = ST_LOCKED;
        end
      end

`ifdef VAULT_PROG_EN
      // A set coinciding with prog falling is dropped: abort wins.
      ST_PROG: begin
        if (!prog) begin
          state_d = ST_OPEN;
          step_d  = '0;
        end else if (set) begin
          prog_write = 1'b1;
          if (step_q == LAST_STEP) begin
            prog_commit = 1'b1;
            state_d     = ST_OPEN;
            step_d      = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_LOCKED;
        step_d  = '0;
      end
    endcase
  end

`ifdef VAULT_PROG_EN
  logic [CODE_W-1:0] shadow_q [NUM_STEPS];

  assign prog_req = prog;

  // NOTE: the shadow array has no reset; each programming pass rewrites
  // entries 0..NUM_STEPS-2 before the commit reads them, so stale data
  // from an aborted or reset pass is never copied into the combination.
  always_ff @(posedge clock) begin
    if (prog_write) begin
      shadow_q[step_q] <= vault_code;
    end
  end

  // The last entry comes straight from the dial so the whole combination
  // lands on the same edge as the final set.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        comb_q[i] <= CODE_W'(default_code(i));
      end
    end else if (prog_commit) begin
      for (int i = 0; i < NUM_STEPS - 1; i++) begin
        comb_q[i] <= shadow_q[i];
      end
      comb_q[NUM_STEPS-1] <= vault_code;
    end
  end
`else
  logic unused_prog;

  assign prog_req    = 1'b0;
  assign unused_prog = ^{prog, set, prog_write, prog_commit};

  for (genvar g = 0; g < NUM_STEPS; g++) begin : g_default_code
    assign comb_q[g] = CODE_W'(default_code(g));
  end
`endif

  // Output logic
  always_comb begin
    unlocked   = (state_q == ST_OPEN) || (state_q == ST_PROG);
    lockout    = (state_q == ST_LOCKOUT);
    step       = ((state_q == ST_ENTRY) || (state_q == ST_PROG)) ? step_q : '0;
    fail_count = fail_q;

    led                   = '0;
    led[LED_LOCKED]       = (state_q == ST_LOCKED);
    led[LED_ENTRY]        = (state_q == ST_ENTRY);
    led[LED_UNLOCKED]     = unlocked;
    led[LED_LOCKOUT]      = lockout;
    led[LED_DIR]          = direction;
    led[LED_CODE_LSB +: 5] = 5'(vault_code);
  end

endmodule

// File: tb/tb_vault_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vault_sequencer
// Directed bench for vault_sequencer with default parameters (combination
// 7,20,3, three failures, 1024-cycle lockout). Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// consumed the stimulus. The programming section follows VAULT_PROG_EN.
// -----------------------------------------------------------------------------
module tb_vault_sequencer;

  localparam int CODE_W         = 5;
  localparam int NUM_STEPS      = 3;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 1024;

  logic              clock      = 1'b0;
  logic              n_reset    = 1'b0;
  logic              direction  = 1'b0;
  logic [CODE_W-1:0] vault_code = '0;
  logic              code_valid = 1'b0;
  logic              prog       = 1'b0;
  logic              set        = 1'b0;
  logic              unlocked;
  logic              lockout;
  logic [1:0]        step;
  logic [1:0]        fail_count;
  logic [9:0]        led;

  int n_compared   = 0;
  int n_mismatched = 0;
  int lock_cycles;

  vault_sequencer #(
    .CODE_W        (CODE_W),
    .NUM_STEPS     (NUM_STEPS),
    .MAX_FAILS     (MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .direction (direction),
    .vault_code(vault_code),
    .code_valid(code_valid),
    .prog      (prog),
    .set       (set),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .step      (step),
    .fail_count(fail_count),
    .led       (led)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One detent move; called on a falling edge, returns on the next one.
  task automatic move(input logic dir, input logic [CODE_W-1:0] code);
    direction  = dir;
    vault_code = code;
    code_valid = 1'b1;
    @(negedge clock);
    code_valid = 1'b0;
  endtask

  task automatic sweep_up(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) move(1'b1, CODE_W'(c));
  endtask

  task automatic open_vault(input int a, input int b, input int c);
    move(1'b0, '0);
    move(1'b1, CODE_W'(a));
    move(1'b0, CODE_W'(b));
    move(1'b1, CODE_W'(c));
  endtask

  // From OPEN: first down move enters RELOCK, down to 0 then locks.
  task automatic relock();
    move(1'b0, '0);
    move(1'b0, '0);
  endtask

  task automatic set_code(input logic [CODE_W-1:0] code);
    vault_code = code;
    set        = 1'b1;
    @(negedge clock);
    set = 1'b0;
  endtask

  // Counts cycles with lockout high while hammering the inputs, bounded.
  task automatic wait_lockout(output int cycles);
    cycles = 0;
    while (lockout && cycles < 4 * LOCKOUT_CYCLES) begin
      direction  = 1'b0;
      vault_code = '0;
      code_valid = 1'b1;
      prog       = 1'b1;
      set        = 1'b1;
      cycles++;
      @(negedge clock);
    end
    code_valid = 1'b0;
    prog       = 1'b0;
    set        = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 n_reset = 1'b0;
    #1;
    check({tag, "_led"},     32'(led[3:0]), 32'h1);
    check({tag, "_lockout"}, 32'(lockout),  32'h0);
    check({tag, "_step"},    32'(step),     32'h0);
    check({tag, "_fails"},   32'(fail_count), 32'h0);
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_led",      32'(led[3:0]),   32'h1);
    check("rst_unlocked", 32'(unlocked),   32'h0);
    check("rst_lockout",  32'(lockout),    32'h0);
    check("rst_step",     32'(step),       32'h0);
    check("rst_fails",    32'(fail_count), 32'h0);
    @(negedge clock);
    n_reset = 1'b1;

    // Start entry, climb toward 7, then undershoot the down step to 20
    move(1'b0, '0);
    check("entry_led", 32'(led[3:0]), 32'h2);
    check("entry_step0", 32'(step), 32'h0);
    sweep_up(1, 6);
    check("below_target_stays", 32'(led[3:0]), 32'h2);
    move(1'b1, 5'd7);
    check("hit_step1", 32'(step), 32'h1);
    move(1'b0, 5'd6);
    check("down_over_unlocked", 32'(unlocked), 32'h0);
    check("down_over_fails", 32'(fail_count), 32'h1);
    check("down_over_led", 32'(led[3:0]), 32'h1);

    // Correct combination, back-to-back strobes
    move(1'b0, '0);
    move(1'b1, 5'd7);
    move(1'b0, 5'd20);
    check("hit_step2", 32'(step), 32'h2);
    move(1'b1, 5'd3);
    check("open_unlocked", 32'(unlocked), 32'h1);
    check("open_fails_clear", 32'(fail_count), 32'h0);
    check("open_step", 32'(step), 32'h0);
    check("open_led", 32'(led[3:0]), 32'h4);

    // LED pass-through of direction and dial position
    direction  = 1'b1;
    vault_code = 5'd22;
    #1;
    check("led_passthru", 32'(led[9:4]), 32'h2d);
    @(negedge clock);

    // Relock
    move(1'b0, 5'd5);
    check("relock_unlocked", 32'(unlocked), 32'h0);
    check("relock_led", 32'(led[3:0]), 32'h0);
    move(1'b0, 5'd2);
    move(1'b1, 5'd0);
    check("relock_holds", 32'(led[3:0]), 32'h0);
    move(1'b0, '0);
    check("relock_locked", 32'(led[3:0]), 32'h1);

    // Up 1..8: 7 is a hit, 8 is then an up move on a down step
    move(1'b0, '0);
    sweep_up(1, 8);
    check("up8_fails", 32'(fail_count), 32'h1);
    check("up8_led", 32'(led[3:0]), 32'h1);
    // Up past the target
    move(1'b0, '0);
    move(1'b1, 5'd9);
    check("up_over_fails", 32'(fail_count), 32'h2);
    // Up wrap to 0 is the third failure
    move(1'b0, '0);
    move(1'b1, 5'd0);
    check("lockout_on", 32'(lockout), 32'h1);
    check("lockout_fails", 32'(fail_count), 32'h3);
    check("lockout_led", 32'(led[3:0]), 32'h8);
    check("lockout_unlocked", 32'(unlocked), 32'h0);

    // Duration, inputs ignored, then LOCKED with failures cleared
    wait_lockout(lock_cycles);
    check("lockout_cycles", 32'(lock_cycles), 32'(LOCKOUT_CYCLES));
    check("after_lockout_led", 32'(led[3:0]), 32'h1);
    check("after_lockout_fails", 32'(fail_count), 32'h0);

    // Down step: above target stays, all-ones wrap fails
    move(1'b0, '0);
    move(1'b1, 5'd7);
    move(1'b0, 5'd25);
    check("down_above_stays", 32'(step), 32'h1);
    move(1'b0, 5'd31);
    check("down_wrap_fails", 32'(fail_count), 32'h1);

    // Wrong direction on step 0, twice, into lockout; reset mid-lockout
    move(1'b0, '0);
    move(1'b0, 5'd4);
    check("wrongdir_fails", 32'(fail_count), 32'h2);
    move(1'b0, '0);
    move(1'b0, 5'd4);
    check("wrongdir_lockout", 32'(lockout), 32'h1);
    repeat (100) @(negedge clock);
    check("lockout_mid", 32'(lockout), 32'h1);
    async_reset("rst_lockout");

    // Reset mid-entry, then the default combination still opens
    move(1'b0, '0);
    move(1'b1, 5'd7);
    check("pre_rst_step", 32'(step), 32'h1);
    async_reset("rst_entry");
    open_vault(7, 20, 3);
    check("reopen_default", 32'(unlocked), 32'h1);

`ifdef VAULT_PROG_EN
    // Program 4, 9, 2
    prog = 1'b1;
    @(negedge clock);
    check("prog_unlocked", 32'(unlocked), 32'h1);
    check("prog_step0", 32'(step), 32'h0);
    set_code(5'd4);
    check("prog_step1", 32'(step), 32'h1);
    set_code(5'd9);
    set_code(5'd2);
    prog = 1'b0;
    @(negedge clock);
    check("prog_done_open", 32'(unlocked), 32'h1);
    check("prog_done_step", 32'(step), 32'h0);
    relock();
    check("prog_relocked", 32'(led[3:0]), 32'h1);
    // Old first entry 7 now overshoots 4
    move(1'b0, '0);
    move(1'b1, 5'd7);
    check("old_code_fails", 32'(fail_count), 32'h1);
    open_vault(4, 9, 2);
    check("new_code_opens", 32'(unlocked), 32'h1);

    // Abort after two sets; a set on the falling prog edge is dropped
    prog = 1'b1;
    @(negedge clock);
    set_code(5'd11);
    set_code(5'd12);
    check("abort_step2", 32'(step), 32'h2);
    prog       = 1'b0;
    set        = 1'b1;
    vault_code = 5'd13;
    @(negedge clock);
    set = 1'b0;
    check("abort_open", 32'(unlocked), 32'h1);
    check("abort_step", 32'(step), 32'h0);
    relock();
    open_vault(4, 9, 2);
    check("abort_keeps_code", 32'(unlocked), 32'h1);

    // Reset restores the defaults
    relock();
    async_reset("rst_prog");
    open_vault(7, 20, 3);
    check("rst_restores_code", 32'(unlocked), 32'h1);
`else
    // prog and set are ignored; OPEN stays OPEN
    prog = 1'b1;
    @(negedge clock);
    check("noprog_step", 32'(step), 32'h0);
    check("noprog_open", 32'(led[3:0]), 32'h4);
    set_code(5'd4);
    check("noprog_set_ignored", 32'(step), 32'h0);
    prog = 1'b0;
    relock();
    open_vault(7, 20, 3);
    check("noprog_code_fixed", 32'(unlocked), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
